// File: rtl/srm_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, status bit positions,
// pipeline-register states and the default datapath width.
package srm_pkg;
  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } aluop_e;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_e;
endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU producing the result and {V,N,Z} flags.
// Signed-overflow detection only exists when EXEC_STAGE_OVF_EN is defined.
module alu
  import srm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [2:0]       o_flags
);
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (aluop_e'(i_op))
      ALU_ADD: w_result = i_a + i_b;
      ALU_SUB: w_result = i_a - i_b;
      ALU_AND: w_result = i_a & i_b;
      ALU_NOT: w_result = ~i_b;
      default: w_result = '0;
    endcase
  end

  always_comb begin
    o_flags       = 3'b000;
    o_flags[ST_Z] = (w_result == '0);
    o_flags[ST_N] = w_result[WIDTH-1];
`ifdef EXEC_STAGE_OVF_EN
    case (aluop_e'(i_op))
      ALU_ADD: o_flags[ST_V] = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_result[WIDTH-1] != i_a[WIDTH-1]);
      ALU_SUB: o_flags[ST_V] = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_result[WIDTH-1] != i_a[WIDTH-1]);
      default: o_flags[ST_V] = 1'b0;
    endcase
`endif
  end

  assign o_result = w_result;
endmodule

// File: rtl/exec_stage.sv
// Execute stage: one-entry valid/ready pipeline register around the ALU,
// status flags and a delivered-result counter. Optional macro: EXEC_STAGE_OVF_EN.
module exec_stage
  import srm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] sout,
  input  logic             asel,
  input  logic [1:0]       aluop,
  input  logic             loads,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       status,
  output logic [15:0]      ops_done
);
  pipe_state_e      r_state, w_next;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic [15:0]      r_ops;
  logic [WIDTH-1:0] w_a, w_result;
  logic [2:0]       w_flags;
  logic             w_accept, w_deliver;

  assign w_a       = asel ? '0 : ain;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_a),
    .i_b      (sout),
    .i_op     (aluop),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_next;
  end

  // Accept while full implies a same-cycle delivery, so the register stays full.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_next = ST_FULL;
      ST_FULL:  if (out_ready && !w_accept) w_next = ST_EMPTY;
      default:  w_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == ST_FULL);
    in_ready  = (r_state == ST_EMPTY) || out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c      <= '0;
      r_status <= 3'b000;
      r_ops    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_c <= w_result;
        if (loads) r_status <= w_flags;
      end
      if (w_deliver) r_ops <= r_ops + 16'd1;
    end
  end

  assign c        = r_c;
  assign status   = r_status;
  assign ops_done = r_ops;
endmodule
